// File: rtl/spi_cond_pkg.sv
// Shared channel indices and per-channel reset levels for the SPI pin conditioner.
package spi_cond_pkg;

    localparam int unsigned CH_SCLK = 0;
    localparam int unsigned CH_CS   = 1;
    localparam int unsigned CH_MOSI = 2;
    localparam int unsigned NUM_CH  = 3;

    // Bit index = channel; cs idles high (deselected), sclk and mosi idle low.
    localparam logic [NUM_CH-1:0] COND_RST_VAL = 3'b010;

endpackage

// File: rtl/spi_cond_channel.sv
// One conditioned pin: 2-flop synchronizer, optional debounce, registered edge pulses.
// Debounce counter is present only when SPI_COND_DEBOUNCE_EN is defined.
module spi_cond_channel #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic cond,
    output logic pos,
    output logic neg
);

    if (WAIT_CYCLES < 1) begin : g_wait_range
        $error("spi_cond_channel: WAIT_CYCLES must be >= 1");
    end

    logic s1;
    logic s2;
    logic cond_nxt;

    // Sync flops reset to the idle level so leaving reset never looks like activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

`ifdef SPI_COND_DEBOUNCE_EN
    localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Count consecutive cycles s2 disagrees with cond; any agreement restarts the count.
    always_comb begin
        cnt_nxt  = '0;
        cond_nxt = cond;
        if (s2 != cond) begin
            if (cnt == CNT_LAST) begin
                cond_nxt = s2;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    always_comb begin
        cond_nxt = s2;
    end
`endif

    // Pulses are registered alongside cond so they line up with the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond <= RST_VAL;
            pos  <= 1'b0;
            neg  <= 1'b0;
        end else begin
            cond <= cond_nxt;
            pos  <= cond_nxt & ~cond;
            neg  <= ~cond_nxt & cond;
        end
    end

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions raw SPI pins (sclk, cs, mosi) into clk-synchronous levels and edge pulses.
// Define SPI_COND_DEBOUNCE_EN to enable the WAIT_CYCLES debounce filter.
module spi_input_conditioner
    import spi_cond_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_cond,
    output logic sclk_pos,
    output logic sclk_neg,
    output logic cs_cond,
    output logic cs_neg,
    output logic cs_pos,
    output logic mosi_cond
);

    logic mosi_pos_unused;
    logic mosi_neg_unused;

    spi_cond_channel #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RST_VAL     (COND_RST_VAL[CH_SCLK])
    ) u_sclk (
        .clk   (clk),
        .reset (reset),
        .pin   (sclk_pin),
        .cond  (sclk_cond),
        .pos   (sclk_pos),
        .neg   (sclk_neg)
    );

    spi_cond_channel #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RST_VAL     (COND_RST_VAL[CH_CS])
    ) u_cs (
        .clk   (clk),
        .reset (reset),
        .pin   (cs_pin),
        .cond  (cs_cond),
        .pos   (cs_pos),
        .neg   (cs_neg)
    );

    // mosi is a pure level; its edge pulses have no consumer.
    spi_cond_channel #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RST_VAL     (COND_RST_VAL[CH_MOSI])
    ) u_mosi (
        .clk   (clk),
        .reset (reset),
        .pin   (mosi_pin),
        .cond  (mosi_cond),
        .pos   (mosi_pos_unused),
        .neg   (mosi_neg_unused)
    );

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Scoreboard bench for spi_input_conditioner: directed scenarios plus random pin activity.
module tb_spi_input_conditioner;
    import spi_cond_pkg::*;

    localparam int unsigned WAIT_CYCLES = 3;
`ifdef SPI_COND_DEBOUNCE_EN
    localparam int W_EFF = WAIT_CYCLES;
`else
    localparam int W_EFF = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic sclk_pin, cs_pin, mosi_pin;
    logic sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_neg, cs_pos, mosi_cond;

    always #5 clk = ~clk;

    spi_input_conditioner #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_pin  (sclk_pin),
        .cs_pin    (cs_pin),
        .mosi_pin  (mosi_pin),
        .sclk_cond (sclk_cond),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .cs_cond   (cs_cond),
        .cs_neg    (cs_neg),
        .cs_pos    (cs_pos),
        .mosi_cond (mosi_cond)
    );

    typedef struct packed {
        logic sclk_cond;
        logic sclk_pos;
        logic sclk_neg;
        logic cs_cond;
        logic cs_neg;
        logic cs_pos;
        logic mosi_cond;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a pin is seen two edges late; the level follows once the
    // delayed value has been different from it for W_EFF edges in a row.
    logic m_d1  [NUM_CH];
    logic m_d2  [NUM_CH];
    logic m_last[NUM_CH];
    int   m_run [NUM_CH];
    logic m_lvl [NUM_CH];
    logic m_up  [NUM_CH];
    logic m_dn  [NUM_CH];

    task automatic model_edge(input logic rst, input logic [2:0] pins);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_up[ch] = 1'b0;
            m_dn[ch] = 1'b0;
            if (rst) begin
                m_d1[ch]   = COND_RST_VAL[ch];
                m_d2[ch]   = COND_RST_VAL[ch];
                m_last[ch] = COND_RST_VAL[ch];
                m_run[ch]  = 0;
                m_lvl[ch]  = COND_RST_VAL[ch];
            end else begin
                logic seen;
                seen = m_d2[ch];
                m_run[ch]  = (seen == m_last[ch]) ? m_run[ch] + 1 : 1;
                m_last[ch] = seen;
                if (seen != m_lvl[ch] && m_run[ch] >= W_EFF) begin
                    m_lvl[ch] = seen;
                    m_up[ch]  = seen;
                    m_dn[ch]  = ~seen;
                end
                m_d2[ch] = m_d1[ch];
                m_d1[ch] = pins[ch];
            end
        end
    endtask

    // pins bit order: [0]=sclk, [1]=cs, [2]=mosi
    task automatic cyc(input logic rst, input logic [2:0] pins);
        obs_t e;
        @(negedge clk);
        reset    = rst;
        sclk_pin = pins[0];
        cs_pin   = pins[1];
        mosi_pin = pins[2];
        model_edge(rst, pins);
        e.sclk_cond = m_lvl[CH_SCLK];
        e.sclk_pos  = m_up[CH_SCLK];
        e.sclk_neg  = m_dn[CH_SCLK];
        e.cs_cond   = m_lvl[CH_CS];
        e.cs_neg    = m_dn[CH_CS];
        e.cs_pos    = m_up[CH_CS];
        e.mosi_cond = m_lvl[CH_MOSI];
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per clock edge; also gathers transaction statistics.
    int         cnt_sclk_pos = 0, cnt_sclk_neg = 0, cnt_cs_neg = 0, cnt_cs_pos = 0;
    logic [7:0] rx_byte = 8'h00;

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_neg, cs_pos, mosi_cond};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got sclk c/p/n=%b%b%b cs c/n/p=%b%b%b mosi=%b, expected %b%b%b %b%b%b %b",
                             $time, a.sclk_cond, a.sclk_pos, a.sclk_neg, a.cs_cond, a.cs_neg,
                             a.cs_pos, a.mosi_cond, e.sclk_cond, e.sclk_pos, e.sclk_neg,
                             e.cs_cond, e.cs_neg, e.cs_pos, e.mosi_cond);
                end
                if (sclk_pos === 1'b1) begin
                    cnt_sclk_pos++;
                    rx_byte = {rx_byte[6:0], mosi_cond};
                end
                if (sclk_neg === 1'b1) cnt_sclk_neg++;
                if (cs_neg === 1'b1)   cnt_cs_neg++;
                if (cs_pos === 1'b1)   cnt_cs_pos++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
    endtask

    localparam logic [2:0] IDLE = 3'b010;

    initial begin
        int         sp0, sn0, cn0, cp0;
        logic [7:0] tx;
        logic [2:0] pins;
        reset = 1'b1;
        sclk_pin = 1'b1;
        cs_pin   = 1'b0;
        mosi_pin = 1'b1;

        // Reset with pins sclk=1, cs=0, mosi=1, then release.
        repeat (4)  cyc(1'b1, 3'b101);
        repeat (10) cyc(1'b0, 3'b101);
        repeat (10) cyc(1'b0, IDLE);

        // Single sclk rise: latency check.
        repeat (10) cyc(1'b0, 3'b011);
        repeat (10) cyc(1'b0, IDLE);

        // cs glitches of 2 and 3 cycles.
        repeat (2)  cyc(1'b0, 3'b000);
        repeat (10) cyc(1'b0, IDLE);
        repeat (3)  cyc(1'b0, 3'b000);
        repeat (12) cyc(1'b0, IDLE);

        // Transaction: 8 sclk periods of 6 low / 6 high, mosi MSB first.
        drain();
        sp0 = cnt_sclk_pos; sn0 = cnt_sclk_neg; cn0 = cnt_cs_neg; cp0 = cnt_cs_pos;
        tx = 8'hA5;
        repeat (10) cyc(1'b0, 3'b000);
        for (int b = 7; b >= 0; b--) begin
            repeat (6) cyc(1'b0, {tx[b], 1'b0, 1'b0});
            repeat (6) cyc(1'b0, {tx[b], 1'b0, 1'b1});
        end
        repeat (6)  cyc(1'b0, 3'b000);
        repeat (12) cyc(1'b0, IDLE);
        drain();
        chk("txn_sclk_pos", cnt_sclk_pos - sp0, 8);
        chk("txn_sclk_neg", cnt_sclk_neg - sn0, 8);
        chk("txn_cs_neg",   cnt_cs_neg - cn0,   1);
        chk("txn_cs_pos",   cnt_cs_pos - cp0,   1);
        chk("txn_mosi_byte", int'(rx_byte), int'(tx));

        // sclk rise interrupted by reset two edges later.
        repeat (2)  cyc(1'b0, 3'b011);
        repeat (2)  cyc(1'b1, 3'b011);
        repeat (10) cyc(1'b0, 3'b011);
        repeat (10) cyc(1'b0, IDLE);

        // Random pin activity with occasional reset.
        pins = IDLE;
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if ($urandom_range(3, 0) == 0) pins[ch] = ~pins[ch];
            end
            cyc(($urandom_range(199, 0) == 0), pins);
        end
        repeat (10) cyc(1'b0, IDLE);

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
